uart_irq_ctrl: RTL and testbench

- Interrupt controller for the UART core.
- Edge-detects the 8 UART event sources and latches them into the sticky IRQ_EVENT register.
- Applies IRQ_EN (capture enable) and IRQ_MASK (output suppress), and drives a single registered level interrupt to the system.
- Sits between the UART datapath (FIFOs, TX/RX engines) and the APB register file; the register file owns the address decode.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_irq_coalescer.sv | 89 ++++++++
 rtl/uart_irq_ctrl.sv | 113 +++++++++++
 tb/tb_uart_irq_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART core.
//   IRQ_*                 bit index of each interrupt source in IRQ_EN/MASK/EVENT
//   IRQ_EVENTS_NUM        number of interrupt sources
//   UART_IRQ_COAL_CNT_W   width of the coalescing threshold/timeout counters
//   uart_irq_coal_st_t    state encoding of the interrupt coalescer FSM
//   uart_irq_regs_t       register-file view; IRQ fields occupy the low byte
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int IRQ_EVENTS_NUM = 8;

    localparam int IRQ_TX_DONE      = 0;
    localparam int IRQ_RX_DONE      = 1;
    localparam int IRQ_DFIFO_ERROR  = 2;
    localparam int IRQ_DFIFO_EMPTY  = 3;
    localparam int IRQ_UFIFO_ERROR  = 4;
    localparam int IRQ_UFIFO_FULL   = 5;
    localparam int IRQ_PARITY_ERR   = 6;
    localparam int IRQ_BAD_FRAME    = 7;

    localparam int UART_IRQ_COAL_CNT_W = 8;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_ACCUM,
        IRQ_FIRE
    } uart_irq_coal_st_t;

    typedef struct packed {
        logic [31:0] irq_en;
        logic [31:0] irq_mask;
        logic [31:0] irq_event;
    } uart_irq_regs_t;

endpackage

// File: rtl/uart_irq_coalescer.sv
// -----------------------------------------------------------------------------
// uart_irq_coalescer
// Delays the system interrupt until enough unmasked events have accumulated
// or a timeout has elapsed since the first one.
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   pending_any_i   at least one unmasked event is latched
//   new_cap_i       an unmasked event is being captured on this edge
//   coal_thr_i      event-count threshold
//   coal_tmo_i      timeout in cycles
//   irq_o           registered level interrupt
// -----------------------------------------------------------------------------
module uart_irq_coalescer
    import uart_pkg::*;
#(
    parameter int COAL_CNT_W = UART_IRQ_COAL_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  pending_any_i,
    input  logic                  new_cap_i,
    input  logic [COAL_CNT_W-1:0] coal_thr_i,
    input  logic [COAL_CNT_W-1:0] coal_tmo_i,
    output logic                  irq_o
);

    localparam logic [COAL_CNT_W-1:0] CNT_ONE = COAL_CNT_W'(1);
    localparam logic [COAL_CNT_W:0]   INC_ONE = (COAL_CNT_W + 1)'(1);

    uart_irq_coal_st_t     state_q, state_d;
    logic [COAL_CNT_W-1:0] cnt_q, cnt_d;
    logic [COAL_CNT_W-1:0] tmr_q, tmr_d;
    logic                  irq_q, irq_d;

    // One extra bit so "+1" cannot wrap before the compare.
    logic [COAL_CNT_W:0] cnt_inc, tmr_inc;
    assign cnt_inc = {1'b0, cnt_q} + INC_ONE;
    assign tmr_inc = {1'b0, tmr_q} + INC_ONE;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            IRQ_IDLE: begin
                cnt_d = '0;
                tmr_d = '0;
                if (pending_any_i) begin
                    if (coal_thr_i <= CNT_ONE || coal_tmo_i == '0) state_d = IRQ_FIRE;
                    else                                           state_d = IRQ_ACCUM;
                end
            end
            IRQ_ACCUM: begin
                if (!pending_any_i) begin
                    state_d = IRQ_IDLE;
                end else begin
                    if (tmr_q != '1)               tmr_d = tmr_q + CNT_ONE;
                    if (new_cap_i && cnt_q != '1)  cnt_d = cnt_q + CNT_ONE;
                    if (cnt_inc >= {1'b0, coal_thr_i} || tmr_inc >= {1'b0, coal_tmo_i})
                        state_d = IRQ_FIRE;
                end
            end
            IRQ_FIRE: begin
                if (!pending_any_i) state_d = IRQ_IDLE;
            end
            default: state_d = IRQ_IDLE;
        endcase
        // Registered from the next state so irq_o is a clean flop output.
        irq_d = (state_d == IRQ_FIRE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IRQ_IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            irq_q   <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/uart_irq_ctrl.sv
// -----------------------------------------------------------------------------
// uart_irq_ctrl
// UART interrupt controller: rising-edge detection of the event sources,
// sticky IRQ_EVENT register with write-1-to-clear, IRQ_EN capture enable,
// IRQ_MASK output suppress and one registered level interrupt.
// Optional build macro UART_IRQ_COALESCE_EN adds an interrupt coalescer
// (coal_thr_i / coal_tmo_i ports and uart_irq_coalescer instance).
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   evt_src_i          raw event sources
//   en_wr_i            IRQ_EN write strobe
//   mask_wr_i          IRQ_MASK write strobe
//   evt_clr_i          IRQ_EVENT write-1-to-clear strobe
//   wdata_i            write data shared by the three strobes
//   irq_en_o           current IRQ_EN
//   irq_mask_o         current IRQ_MASK
//   irq_event_o        current IRQ_EVENT
//   irq_pending_o      irq_event_o & ~irq_mask_o
//   irq_o              registered level interrupt
//   coal_thr_i         coalescing event threshold (macro builds only)
//   coal_tmo_i         coalescing timeout in cycles (macro builds only)
// -----------------------------------------------------------------------------
module uart_irq_ctrl
    import uart_pkg::*;
#(
    parameter int EVENTS_NUM = IRQ_EVENTS_NUM,
    parameter int COAL_CNT_W = UART_IRQ_COAL_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [EVENTS_NUM-1:0] evt_src_i,
    input  logic                  en_wr_i,
    input  logic                  mask_wr_i,
    input  logic                  evt_clr_i,
    input  logic [EVENTS_NUM-1:0] wdata_i,
    output logic [EVENTS_NUM-1:0] irq_en_o,
    output logic [EVENTS_NUM-1:0] irq_mask_o,
    output logic [EVENTS_NUM-1:0] irq_event_o,
    output logic [EVENTS_NUM-1:0] irq_pending_o,
`ifdef UART_IRQ_COALESCE_EN
    input  logic [COAL_CNT_W-1:0] coal_thr_i,
    input  logic [COAL_CNT_W-1:0] coal_tmo_i,
`endif
    output logic                  irq_o
);

    logic [EVENTS_NUM-1:0] src_q, src_d;
    logic [EVENTS_NUM-1:0] en_q, en_d;
    logic [EVENTS_NUM-1:0] mask_q, mask_d;
    logic [EVENTS_NUM-1:0] event_q, event_d;
    logic [EVENTS_NUM-1:0] rise;
    logic [EVENTS_NUM-1:0] clr_bits;

    always_comb begin
        src_d    = evt_src_i;
        rise     = evt_src_i & ~src_q;
        en_d     = en_wr_i   ? wdata_i : en_q;
        mask_d   = mask_wr_i ? wdata_i : mask_q;
        clr_bits = evt_clr_i ? wdata_i : '0;
        // Set is OR-ed in after the clear so a same-cycle capture is never lost.
        event_d  = (event_q & ~clr_bits) | (rise & en_q);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            // All ones: a source already high at reset is not seen as a rise.
            src_q   <= '1;
            en_q    <= '0;
            mask_q  <= '0;
            event_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            src_q   <= src_d;
            en_q    <= en_d;
            mask_q  <= mask_d;
            event_q <= event_d;
        end
    end

    assign irq_en_o      = en_q;
    assign irq_mask_o    = mask_q;
    assign irq_event_o   = event_q;
    assign irq_pending_o = event_q & ~mask_q;

`ifdef UART_IRQ_COALESCE_EN
    logic new_cap;
    assign new_cap = |(rise & en_q & ~mask_q);

    uart_irq_coalescer #(
        .COAL_CNT_W (COAL_CNT_W)
    ) u_coalescer (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .pending_any_i (|irq_pending_o),
        .new_cap_i     (new_cap),
        .coal_thr_i    (coal_thr_i),
        .coal_tmo_i    (coal_tmo_i),
        .irq_o         (irq_o)
    );
`else
    logic irq_q, irq_d;

    assign irq_d = |irq_pending_o;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) irq_q <= 1'b0;
        else         irq_q <= irq_d;
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_irq_ctrl
// Self-checking bench for uart_irq_ctrl: a table of per-cycle vectors with
// expected register/interrupt values (scoreboard queue), plus hand-written
// sequences for asynchronous reset and, in coalescing builds, the coalescer.
// -----------------------------------------------------------------------------
module tb_uart_irq_ctrl;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic [7:0] evt_src_i;
    logic       en_wr_i, mask_wr_i, evt_clr_i;
    logic [7:0] wdata_i;
    logic [7:0] irq_en_o, irq_mask_o, irq_event_o, irq_pending_o;
    logic       irq_o;
`ifdef UART_IRQ_COALESCE_EN
    logic [7:0] coal_thr_i, coal_tmo_i;
`endif

    always #5 clk_i = ~clk_i;

    uart_irq_ctrl dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .evt_src_i     (evt_src_i),
        .en_wr_i       (en_wr_i),
        .mask_wr_i     (mask_wr_i),
        .evt_clr_i     (evt_clr_i),
        .wdata_i       (wdata_i),
        .irq_en_o      (irq_en_o),
        .irq_mask_o    (irq_mask_o),
        .irq_event_o   (irq_event_o),
        .irq_pending_o (irq_pending_o),
`ifdef UART_IRQ_COALESCE_EN
        .coal_thr_i    (coal_thr_i),
        .coal_tmo_i    (coal_tmo_i),
`endif
        .irq_o         (irq_o)
    );

    typedef struct {
        logic [7:0] src;
        logic       en_wr;
        logic       mask_wr;
        logic       clr;
        logic [7:0] wdata;
        logic [7:0] exp_en;
        logic [7:0] exp_mask;
        logic [7:0] exp_event;
        logic       exp_irq;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] en;
        logic [7:0] mask;
        logic [7:0] ev;
        logic       irq;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic void add(input logic [7:0] src, input logic en_wr, input logic mask_wr,
                                input logic clr, input logic [7:0] wdata,
                                input logic [7:0] e_en, input logic [7:0] e_mask,
                                input logic [7:0] e_ev, input logic e_irq);
        vec_t v;
        v.src = src; v.en_wr = en_wr; v.mask_wr = mask_wr; v.clr = clr; v.wdata = wdata;
        v.exp_en = e_en; v.exp_mask = e_mask; v.exp_event = e_ev; v.exp_irq = e_irq;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs at the falling edge, let one rising edge pass,
    // and return at the next falling edge where outputs are sampled.
    task automatic tick(input logic [7:0] src, input logic en_wr, input logic mask_wr,
                        input logic clr, input logic [7:0] wdata);
        evt_src_i = src;
        en_wr_i   = en_wr;
        mask_wr_i = mask_wr;
        evt_clr_i = clr;
        wdata_i   = wdata;
        @(posedge clk_i);
        @(negedge clk_i);
        en_wr_i   = 1'b0;
        mask_wr_i = 1'b0;
        evt_clr_i = 1'b0;
    endtask

    initial begin
        exp_t e;
        exp_t got;

        rstn_i    = 1'b0;
        evt_src_i = 8'h08;
        en_wr_i   = 1'b0;
        mask_wr_i = 1'b0;
        evt_clr_i = 1'b0;
        wdata_i   = 8'h00;
`ifdef UART_IRQ_COALESCE_EN
        // Threshold 1 gives the same timing as the plain registered interrupt.
        coal_thr_i = 8'd1;
        coal_tmo_i = 8'd20;
`endif

        //   src    en  mk  clr wdata   en     mask   event  irq
        // Source already high at reset, then drop and re-raise bit 3.
        add(8'h08, 1, 0, 0, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);
        add(8'h08, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
        add(8'h00, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
        add(8'h08, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h08, 0);
        add(8'h08, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h08, 1);
        // Clear, EN = 0x01, pulses on bits 0 and 1, W1C bit 0.
        add(8'h08, 0, 0, 1, 8'h08, 8'hFF, 8'h00, 8'h00, 1);
        add(8'h08, 1, 0, 0, 8'h01, 8'h01, 8'h00, 8'h00, 0);
        add(8'h0B, 0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h01, 0);
        add(8'h08, 0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h01, 1);
        add(8'h08, 0, 0, 1, 8'h01, 8'h01, 8'h00, 8'h00, 1);
        add(8'h08, 0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 0);
        // Masked event 2, then unmask.
        add(8'h08, 1, 0, 0, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);
        add(8'h08, 0, 1, 0, 8'h04, 8'hFF, 8'h04, 8'h00, 0);
        add(8'h0C, 0, 0, 0, 8'h00, 8'hFF, 8'h04, 8'h04, 0);
        add(8'h0C, 0, 0, 0, 8'h00, 8'hFF, 8'h04, 8'h04, 0);
        add(8'h0C, 0, 1, 0, 8'h00, 8'hFF, 8'h00, 8'h04, 0);
        add(8'h0C, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h04, 1);
        // Disabling EN keeps the latched event and blocks new captures.
        add(8'h0C, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h04, 1);
        add(8'h0D, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h04, 1);
        // Same-cycle rise on bit 6 and W1C of bits 6 and 2: set wins on bit 6.
        add(8'h0C, 1, 0, 0, 8'hFF, 8'hFF, 8'h00, 8'h04, 1);
        add(8'h4C, 0, 0, 1, 8'h44, 8'hFF, 8'h00, 8'h40, 1);
        add(8'h4C, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h40, 1);
        // All three strobes together.
        add(8'h4C, 1, 1, 1, 8'h40, 8'h40, 8'h40, 8'h00, 1);
        add(8'h4C, 0, 0, 0, 8'h00, 8'h40, 8'h40, 8'h00, 0);
        // Every source rises with everything enabled.
        add(8'h00, 1, 0, 0, 8'hFF, 8'hFF, 8'h40, 8'h00, 0);
        add(8'h00, 0, 1, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
        add(8'hFF, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'hFF, 0);
        add(8'hFF, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1);

        // Reset values.
        #12;
        check("reset_en",      irq_en_o,      8'h00);
        check("reset_mask",    irq_mask_o,    8'h00);
        check("reset_event",   irq_event_o,   8'h00);
        check("reset_pending", irq_pending_o, 8'h00);
        check("reset_irq",     {7'd0, irq_o}, 8'h00);
        @(negedge clk_i);
        rstn_i = 1'b1;

        foreach (vecs[i]) begin
            e.idx  = i;
            e.en   = vecs[i].exp_en;
            e.mask = vecs[i].exp_mask;
            e.ev   = vecs[i].exp_event;
            e.irq  = vecs[i].exp_irq;
            sb.push_back(e);
            tick(vecs[i].src, vecs[i].en_wr, vecs[i].mask_wr, vecs[i].clr, vecs[i].wdata);
            got = sb.pop_front();
            check($sformatf("v%0d_en", got.idx),      irq_en_o,      got.en);
            check($sformatf("v%0d_mask", got.idx),    irq_mask_o,    got.mask);
            check($sformatf("v%0d_event", got.idx),   irq_event_o,   got.ev);
            check($sformatf("v%0d_pending", got.idx), irq_pending_o, got.ev & ~got.mask);
            check($sformatf("v%0d_irq", got.idx),     {7'd0, irq_o}, {7'd0, got.irq});
        end

        // Asynchronous reset while the interrupt is up and all events latched.
        rstn_i = 1'b0;
        #1;
        check("async_rst_en",      irq_en_o,      8'h00);
        check("async_rst_mask",    irq_mask_o,    8'h00);
        check("async_rst_event",   irq_event_o,   8'h00);
        check("async_rst_pending", irq_pending_o, 8'h00);
        check("async_rst_irq",     {7'd0, irq_o}, 8'h00);
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick(8'hFF, 1, 0, 0, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            tick(8'hFF, 0, 0, 0, 8'h00);
            check($sformatf("post_rst_event_%0d", i), irq_event_o,   8'h00);
            check($sformatf("post_rst_irq_%0d", i),   {7'd0, irq_o}, 8'h00);
        end

`ifdef UART_IRQ_COALESCE_EN
        coal_thr_i = 8'd3;
        coal_tmo_i = 8'd20;
        tick(8'h00, 0, 0, 0, 8'h00);
        // Three captures two cycles apart: interrupt one edge after the third.
        begin
            logic [7:0] pat [6];
            logic       exp_irq [6];
            pat[0] = 8'h01; pat[1] = 8'h00; pat[2] = 8'h02;
            pat[3] = 8'h00; pat[4] = 8'h04; pat[5] = 8'h00;
            exp_irq[0] = 0; exp_irq[1] = 0; exp_irq[2] = 0;
            exp_irq[3] = 0; exp_irq[4] = 0; exp_irq[5] = 1;
            for (int i = 0; i < 6; i++) begin
                tick(pat[i], 0, 0, 0, 8'h00);
                check($sformatf("coal_thr_irq_%0d", i), {7'd0, irq_o}, {7'd0, exp_irq[i]});
            end
        end
        tick(8'h00, 0, 0, 1, 8'hFF);
        tick(8'h00, 0, 0, 0, 8'h00);
        check("coal_thr_irq_clr", {7'd0, irq_o}, 8'h00);
        tick(8'h00, 0, 0, 0, 8'h00);

        // Single capture: interrupt 20 cycles after entering ACCUM.
        tick(8'h08, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 21; i++) begin
            tick(8'h00, 0, 0, 0, 8'h00);
            if (i == 20) check("coal_tmo_irq_before", {7'd0, irq_o}, 8'h00);
            if (i == 21) check("coal_tmo_irq_fire",   {7'd0, irq_o}, 8'h01);
        end
        tick(8'h00, 0, 0, 1, 8'hFF);
        tick(8'h00, 0, 0, 0, 8'h00);
        tick(8'h00, 0, 0, 0, 8'h00);

        // Software clear during ACCUM: back to IDLE, no interrupt.
        tick(8'h10, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) tick(8'h00, 0, 0, 0, 8'h00);
        tick(8'h00, 0, 0, 1, 8'hFF);
        for (int i = 0; i < 25; i++) begin
            tick(8'h00, 0, 0, 0, 8'h00);
            check($sformatf("coal_clr_irq_%0d", i), {7'd0, irq_o}, 8'h00);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
